// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source producing registered sync, blank and pixel coordinates
// Ports: clock, reset (synchronous, active-high), pix_en (pixel advance enable);
//        row/col (coordinates while visible, else 0), hsync/vsync (active at *_POL),
//        blank (high outside visible area), line_start/frame_start (single-clock strobes).
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BACK    = 64,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG  = H_VISIBLE + H_FRONT;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_VISIBLE + V_FRONT;
  localparam int VS_END  = VS_BEG + V_SYNC;
  logic [10:0] h_cnt, v_cnt;
  logic visible, h_act, v_act, h_last, v_last;
  always_comb begin
    visible = (h_cnt < 11'(H_VISIBLE)) && (v_cnt < 11'(V_VISIBLE));
    h_act   = (h_cnt >= 11'(HS_BEG)) && (h_cnt < 11'(HS_END));
    v_act   = (v_cnt >= 11'(VS_BEG)) && (v_cnt < 11'(VS_END));
    h_last  = h_cnt == 11'(H_TOTAL - 1);
    v_last  = v_cnt == 11'(V_TOTAL - 1);
  end
  // Outputs describe the position held before the edge; counters advance on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      row         <= '0;
      col         <= '0;
      hsync       <= !HSYNC_POL;
      vsync       <= !VSYNC_POL;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      row         <= visible ? v_cnt[9:0] : '0;
      col         <= visible ? h_cnt[9:0] : '0;
      hsync       <= h_act ~^ HSYNC_POL;
      vsync       <= v_act ~^ VSYNC_POL;
      blank       <= !visible;
      line_start  <= h_cnt == '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      h_cnt       <= h_last ? '0 : h_cnt + 11'd1;
      v_cnt       <= h_last ? (v_last ? '0 : v_cnt + 11'd1) : v_cnt;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for a default-timing and a reduced-timing instance
module tb_vga_timing_gen;
  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       ls;
    logic       fs;
  } out_t;
  localparam int   HV[2] = '{800, 8};
  localparam int   HF[2] = '{56, 3};
  localparam int   HS[2] = '{120, 4};
  localparam int   HB[2] = '{64, 5};
  localparam int   VV[2] = '{600, 6};
  localparam int   VF[2] = '{37, 2};
  localparam int   VS[2] = '{6, 3};
  localparam int   VB[2] = '{23, 2};
  localparam logic HP[2] = '{1'b1, 1'b0};
  localparam logic VP[2] = '{1'b1, 1'b1};
  logic clock = 1'b0, reset = 1'b1, pix_en = 1'b0;
  logic [9:0] row0, col0, row1, col1;
  logic hsync0, vsync0, blank0, line_start0, frame_start0;
  logic hsync1, vsync1, blank1, line_start1, frame_start1;
  out_t o0, o1, e0, e1, mo[2];
  out_t q0[$], q1[$];
  int mh[2], mv[2];
  int checks = 0, errors = 0, n = 0, cyc = 0;
  always #5 clock = ~clock;
  vga_timing_gen d0 (
    .clock(clock), .reset(reset), .pix_en(pix_en), .row(row0), .col(col0), .hsync(hsync0),
    .vsync(vsync0), .blank(blank0), .line_start(line_start0), .frame_start(frame_start0)
  );
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) d1 (
    .clock(clock), .reset(reset), .pix_en(pix_en), .row(row1), .col(col1), .hsync(hsync1),
    .vsync(vsync1), .blank(blank1), .line_start(line_start1), .frame_start(frame_start1)
  );
  assign o0 = {row0, col0, hsync0, vsync0, blank0, line_start0, frame_start0};
  assign o1 = {row1, col1, hsync1, vsync1, blank1, line_start1, frame_start1};
  task automatic model(input int k, input logic r, input logic e);
    int ht, vt;
    logic vis;
    ht = HV[k] + HF[k] + HS[k] + HB[k];
    vt = VV[k] + VF[k] + VS[k] + VB[k];
    if (r) begin
      mh[k] = 0;
      mv[k] = 0;
      mo[k] = '{10'd0, 10'd0, !HP[k], !VP[k], 1'b1, 1'b0, 1'b0};
    end else if (e) begin
      vis = (mh[k] < HV[k]) && (mv[k] < VV[k]);
      mo[k].row = vis ? 10'(mv[k]) : 10'd0;
      mo[k].col = vis ? 10'(mh[k]) : 10'd0;
      mo[k].hs = (mh[k] >= HV[k] + HF[k] && mh[k] < HV[k] + HF[k] + HS[k]) ? HP[k] : !HP[k];
      mo[k].vs = (mv[k] >= VV[k] + VF[k] && mv[k] < VV[k] + VF[k] + VS[k]) ? VP[k] : !VP[k];
      mo[k].bl = !vis;
      mo[k].ls = mh[k] == 0;
      mo[k].fs = mh[k] == 0 && mv[k] == 0;
      if (mh[k] == ht - 1) begin
        mh[k] = 0;
        mv[k] = (mv[k] == vt - 1) ? 0 : mv[k] + 1;
      end else mh[k]++;
    end else begin
      mo[k].ls = 1'b0;
      mo[k].fs = 1'b0;
    end
    if (k == 0) q0.push_back(mo[k]);
    else q1.push_back(mo[k]);
  endtask
  task automatic drive(input logic r, input logic e);
    reset = r;
    pix_en = e;
    model(0, r, e);
    model(1, r, e);
    @(posedge clock);
    #1;
    cyc++;
    if (r) n = 0;
    else if (e) n++;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i % 2) == 0);
      e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL reset d0 got %h exp %h", o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL reset d1 got %h exp %h", o1, e1); end
    end
    checks++;
    if ({blank0, hsync0, vsync0} !== 3'b100) begin
      errors++; $display("FAIL reset_levels got %b exp 100", {blank0, hsync0, vsync0});
    end
  endtask
  task automatic test_release();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1);
      e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 3;
      if (o0 !== e0) begin errors++; $display("FAIL release d0 got %h exp %h", o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL release d1 got %h exp %h", o1, e1); end
      if ({row0, col0, blank0, line_start0, frame_start0} !== {10'd0, 10'(i), 1'b0, i == 0, i == 0}) begin
        errors++;
        $display("FAIL release_edge%0d got %h exp %h", i + 1,
                 {row0, col0, blank0, line_start0, frame_start0}, {10'd0, 10'(i), 1'b0, i == 0, i == 0});
      end
    end
  endtask
  task automatic test_horizontal();
    int rise = -1, fall = -1, last_ls = 1;
    logic ph = 1'b0;
    while (n < 2100) begin
      drive(1'b0, 1'b1);
      e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL horiz d0 n=%0d got %h exp %h", n, o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL horiz d1 n=%0d got %h exp %h", n, o1, e1); end
      if (hsync0 && !ph && rise < 0) rise = n;
      if (!hsync0 && ph && fall < 0) fall = n;
      ph = hsync0;
      if (n == 800) begin
        checks++;
        if ({col0, blank0} !== {10'd799, 1'b0}) begin errors++; $display("FAIL col799 got %0d/%b exp 799/0", col0, blank0); end
      end
      if (n == 801) begin
        checks++;
        if ({col0, blank0} !== {10'd0, 1'b1}) begin errors++; $display("FAIL hblank got %0d/%b exp 0/1", col0, blank0); end
      end
      if (line_start0) begin
        checks++;
        if (n - last_ls !== 1040) begin errors++; $display("FAIL line_period got %0d exp 1040", n - last_ls); end
        last_ls = n;
      end
    end
    checks += 2;
    if (rise !== 857) begin errors++; $display("FAIL hsync_rise got %0d exp 857", rise); end
    if (fall !== 977) begin errors++; $display("FAIL hsync_fall got %0d exp 977", fall); end
  endtask
  task automatic frame_run(input int ncyc, input bit alt, input int period, input int vs_len);
    int last = -1, lines = 0, vcnt = 0, frames = 0;
    for (int i = 0; i < ncyc; i++) begin
      drive(1'b0, alt ? (i % 2 == 0) : 1'b1);
      e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL frame d0 cyc=%0d got %h exp %h", cyc, o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL frame d1 cyc=%0d got %h exp %h", cyc, o1, e1); end
      if (frame_start1) begin
        frames++;
        if (last >= 0) begin
          checks += 2;
          if (cyc - last !== period) begin errors++; $display("FAIL frame_period got %0d exp %0d", cyc - last, period); end
          if (lines !== 13) begin errors++; $display("FAIL lines_per_frame got %0d exp 13", lines); end
          if (!alt) begin
            checks++;
            if (vcnt !== vs_len) begin errors++; $display("FAIL vsync_len got %0d exp %0d", vcnt, vs_len); end
          end
        end
        last = cyc; lines = 0; vcnt = 0;
      end
      lines += line_start1;
      vcnt += vsync1;
    end
    checks++;
    if (frames < 2) begin errors++; $display("FAIL frame_count got %0d exp >=2", frames); end
  endtask
  task automatic test_frame();
    frame_run(600, 1'b0, 260, 60);
  endtask
  task automatic test_pix_en_alt();
    frame_run(1200, 1'b1, 520, 0);
  endtask
  task automatic test_reset_mid();
    int k = 0;
    while (!(row1 == 10'd3 && col1 == 10'd4) && k < 300) begin
      drive(1'b0, 1'b1);
      e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL seek d0 got %h exp %h", o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL seek d1 got %h exp %h", o1, e1); end
      k++;
    end
    checks++;
    if (k >= 300) begin errors++; $display("FAIL seek_timeout got %0d exp <300", k); end
    drive(1'b1, 1'b1);
    e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 3;
    if (o0 !== e0) begin errors++; $display("FAIL midreset d0 got %h exp %h", o0, e0); end
    if (o1 !== e1) begin errors++; $display("FAIL midreset d1 got %h exp %h", o1, e1); end
    if ({row1, col1, blank1, hsync1, frame_start1} !== {20'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL midreset_vals got %h exp %h", {row1, col1, blank1, hsync1, frame_start1}, {20'd0, 3'b110});
    end
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b1);
      e0 = q0.pop_front(); e1 = q1.pop_front(); checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL after d0 got %h exp %h", o0, e0); end
      if (o1 !== e1) begin errors++; $display("FAIL after d1 got %h exp %h", o1, e1); end
      if (i == 0) begin
        checks++;
        if ({frame_start0, frame_start1, blank1} !== 3'b110) begin
          errors++; $display("FAIL restart_fs got %b exp 110", {frame_start0, frame_start1, blank1});
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_release();
    test_horizontal();
    test_frame();
    test_pix_en_alt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
